// File: rtl/clock_pkg.sv
// Shared clock-domain constants and the H/M/S time type used by the
// time keeper, alarm, setting and display blocks.
package clock_pkg;

  localparam int TIME_W     = 6;
  localparam int HOUR_MAX   = 23;
  localparam int MINSEC_MAX = 59;

  typedef struct packed {
    logic [TIME_W-1:0] h;
    logic [TIME_W-1:0] m;
    logic [TIME_W-1:0] s;
  } time_t;

endpackage

// File: rtl/time_keeper_if.sv
// Control/status bundle of the time keeper: hold/load controls, load value,
// current time and the per-second / midnight pulses.
interface time_keeper_if;
  import clock_pkg::*;

  logic              HOLD;
  logic              SET_LOAD;
  logic [TIME_W-1:0] SET_H;
  logic [TIME_W-1:0] SET_M;
  logic [TIME_W-1:0] SET_S;
  logic [TIME_W-1:0] internalTime_H;
  logic [TIME_W-1:0] internalTime_M;
  logic [TIME_W-1:0] internalTime_S;
  logic              TICK_1HZ;
  logic              MIDNIGHT_PULSE;

  modport master (
    output HOLD, SET_LOAD, SET_H, SET_M, SET_S,
    input  internalTime_H, internalTime_M, internalTime_S, TICK_1HZ, MIDNIGHT_PULSE
  );

  modport slave (
    input  HOLD, SET_LOAD, SET_H, SET_M, SET_S,
    output internalTime_H, internalTime_M, internalTime_S, TICK_1HZ, MIDNIGHT_PULSE
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-(MAX_VAL+1) counter with load and enable; carry is high while
// enabled at MAX_VAL so the next stage advances on the same edge.
module mod_counter
  import clock_pkg::*;
#(
  parameter int MAX_VAL = MINSEC_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  output logic [TIME_W-1:0] count,
  output logic              carry
);

  localparam logic [TIME_W-1:0] MAX_V = TIME_W'(MAX_VAL);

  assign carry = en && (count == MAX_V);

  // Out-of-range load values collapse to zero so the count never leaves 0..MAX_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val > MAX_V) ? '0 : load_val;
    end else if (en) begin
      count <= carry ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day keeper: prescaler to 1 Hz plus chained S/M/H counters.
// Define TIME_KEEPER_FAST_SIM_EN to divide by FAST_DIV instead of CLK_FREQ.
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int FAST_DIV = 4
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  time_keeper_if.slave  bus
);

`ifdef TIME_KEEPER_FAST_SIM_EN
  localparam int DIV = FAST_DIV;
`else
  localparam int DIV = CLK_FREQ;
`endif
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] prescaler;
  logic             term_cnt;
  logic             advance;
  logic             s_carry;
  logic             m_carry;
  logic             h_carry;
  logic             tick_p1;
  logic             midnight_p1;
  time_t            cur;

  assign term_cnt = (prescaler == PRE_LAST);
  // A load wins over both the terminal count and HOLD.
  assign advance  = term_cnt && !bus.HOLD && !bus.SET_LOAD;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      prescaler   <= '0;
      tick_p1     <= 1'b0;
      midnight_p1 <= 1'b0;
    end else begin
      if (bus.SET_LOAD) begin
        prescaler <= '0;
      end else if (!bus.HOLD) begin
        prescaler <= term_cnt ? '0 : prescaler + 1'b1;
      end
      tick_p1     <= advance;
      midnight_p1 <= h_carry;
    end
  end

  mod_counter #(.MAX_VAL(MINSEC_MAX)) u_sec (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .en       (advance),
    .load     (bus.SET_LOAD),
    .load_val (bus.SET_S),
    .count    (cur.s),
    .carry    (s_carry)
  );

  mod_counter #(.MAX_VAL(MINSEC_MAX)) u_min (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .en       (s_carry),
    .load     (bus.SET_LOAD),
    .load_val (bus.SET_M),
    .count    (cur.m),
    .carry    (m_carry)
  );

  mod_counter #(.MAX_VAL(HOUR_MAX)) u_hour (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .en       (m_carry),
    .load     (bus.SET_LOAD),
    .load_val (bus.SET_H),
    .count    (cur.h),
    .carry    (h_carry)
  );

  assign bus.internalTime_H = cur.h;
  assign bus.internalTime_M = cur.m;
  assign bus.internalTime_S = cur.s;
  assign bus.TICK_1HZ       = tick_p1;
  assign bus.MIDNIGHT_PULSE = midnight_p1;

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, input clock cycles per second.
REQ-002 SHALL have parameter FAST_DIV, default 4, cycles per second when TIME_KEEPER_FAST_SIM_EN is defined.
REQ-003 SHALL have the following ports: CLOCK_50 input 1; one clock for the whole block, rising edge.
REQ-004 RESET_N input 1; reset is asynchronous and active-low.
REQ-005 HOLD input 1; freezes prescaler and time counters while high.
REQ-006 SET_LOAD input 1; one-cycle request to load SET_H/SET_M/SET_S.
REQ-007 SET_H, SET_M, SET_S input 6 each; time value to load.
REQ-008 internalTime_H, internalTime_M, internalTime_S output 6 each; registered current time, binary.
REQ-009 TICK_1HZ output 1; one-cycle pulse per elapsed second.
REQ-010 MIDNIGHT_PULSE output 1; one-cycle pulse on 23:59:59 -> 00:00:00 rollover.

Function
REQ-011 Prescaler SHALL count 0..DIV-1, DIV = CLK_FREQ, or FAST_DIV under the macro; width = $clog2(DIV), minimum 1.
REQ-012 On the edge where the prescaler equals DIV-1 and HOLD=0:
- prescaler wraps to 0;
- the seconds counter advances;
- TICK_1HZ SHALL be 1 in the following cycle only.
REQ-013 Seconds SHALL wrap 59 -> 0 and carry to minutes in the same edge.
REQ-014 Minutes SHALL wrap 59 -> 0 and carry to hours in the same edge.
REQ-015 Hours SHALL wrap 23 -> 0; MIDNIGHT_PULSE SHALL be 1 in the same cycle as the corresponding TICK_1HZ.
REQ-016 Time outputs SHALL never leave ranges H 0..23, M/S 0..59.
REQ-017 SET_LOAD=1 SHALL, at that edge:
- load all three counters;
- clear the prescaler to 0;
- suppress TICK_1HZ and MIDNIGHT_PULSE for the next cycle.
REQ-018 SET_LOAD SHALL take priority over a simultaneous terminal count and over HOLD.
REQ-019 A loaded field out of range (SET_H>23, SET_M>59, SET_S>59) SHALL be loaded as 0; the other fields SHALL load normally.
REQ-020 HOLD=1 SHALL stall the prescaler and counters; TICK_1HZ and MIDNIGHT_PULSE SHALL be 0 while HOLD=1.
REQ-021 Counting SHALL resume from the held prescaler value when HOLD falls; no tick is lost or duplicated.
REQ-022 Time outputs SHALL be driven directly from the counter registers, with no combinational path from inputs.
REQ-023 Loaded values SHALL appear on the outputs in the cycle after SET_LOAD.

Reset
REQ-024 RESET_N=0 SHALL asynchronously clear the prescaler, all time counters, TICK_1HZ and MIDNIGHT_PULSE to 0.
REQ-025 Reset asserted mid-second SHALL discard the partial second; after release the first tick occurs DIV cycles later.
REQ-026 No initial blocks SHALL be relied on for state.

Configuration
REQ-027 Macro TIME_KEEPER_FAST_SIM_EN defined SHALL set DIV = FAST_DIV for simulation; all other behaviour is unchanged.
REQ-028 Macro TIME_KEEPER_FAST_SIM_EN undefined SHALL set DIV = CLK_FREQ; the synthesized build SHALL NOT define it.

Structure
REQ-029 Shared package clock_pkg SHALL hold:
- constants HOUR_MAX=23, MINSEC_MAX=59;
- TIME_W=6;
- a typedef for an H/M/S time struct.
The alarm, setting and display blocks SHALL reuse these.
REQ-030 One sub-module, mod_counter, SHALL be instantiated three times: parameterised max value, with enable, load, load value and carry-out (carry asserted at max while enabled).
REQ-031 The prescaler SHALL live in time_keeper itself, not in mod_counter.

Verification (TIME_KEEPER_FAST_SIM_EN defined, FAST_DIV=4)
REQ-032 Release reset, HOLD=0 -> first TICK_1HZ at cycle 4, then every 4 cycles; S reads 1 after the first tick, 2 after the second.
REQ-033 SET_LOAD with 23:59:58, then 8 cycles -> 23:59:59, then 00:00:00 with MIDNIGHT_PULSE=1 exactly once, coincident with TICK_1HZ.
REQ-034 SET_LOAD with 25:60:07 -> outputs 00:00:07; SET_LOAD with 12:34:56 on a terminal-count cycle -> 12:34:56, no tick next cycle.
REQ-035 HOLD=1 for 10 cycles at prescaler=2 -> outputs constant and no pulses; after release the next tick arrives after exactly 2 more cycles.
REQ-036 RESET_N pulsed low asynchronously (between edges) at 10:20:30 -> 00:00:00 immediately and pulses 0; the next tick comes 4 cycles after release.
REQ-037 Free-run 86400 ticks from 00:00:00 -> returns to 00:00:00 with exactly one MIDNIGHT_PULSE; range assertions from REQ-016 hold throughout.
